dlfloat_operand_loader: RTL and testbench
=========================================

# dlfloat_operand_loader

Upstream stage of the DLFloat16 MAC. Accepts a byte-serial operand stream from the 8-bit pad interface and assembles 16-bit operand pairs (A, B), sending the high byte first, in the same byte order the result path uses. Completed pairs are buffered in a small FIFO and handed to the MAC over a valid/ready handshake. A per-pair `last` tag lets the MAC close a dot-product accumulation.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO depth in operand pairs. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  operand byte.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_last`  in  1  tags the current byte as the last byte of a dot product. Legal only on a B_LO byte.
- `in_ready`  out  1  loader accepts the byte this cycle.
- `out_a`  out  16  operand A of the head pair.
- `out_b`  out  16  operand B of the head pair.
- `out_last`  out  1  the head pair closes the accumulation.
- `out_valid`  out  1  a head pair is present.
- `out_ready`  in  1  MAC consumes the head pair.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err_frame`  out  1  sticky framing error. Cleared only by reset.

## Operation
- A byte is accepted when `in_valid && in_ready`.
- Assembly FSM states: A_HI → A_LO → B_HI → B_LO → A_HI. The FSM advances by exactly one state per accepted byte. Each accepted byte is stored in the matching half of the `a_q`/`b_q` holding registers.
- On an accepted byte in B_LO, {`a_q`, {`b_hi`, `in_data`}, `in_last`} is pushed into the FIFO.
- `in_ready` = (state != B_LO) || !full. The first three bytes of a pair are always accepted. Only the final byte stalls on a full FIFO.
- Framing error: `in_last`=1 on an accepted byte in any state other than B_LO.
  - Sets `err_frame`.
  - Discards the partial pair; nothing is pushed.
  - Forces the FSM to A_HI.
- FIFO behaviour:
  - `out_valid` = (`level` != 0).
  - `out_a`, `out_b` and `out_last` come from the head entry.
  - A pop happens on `out_valid && out_ready`.
  - Push and pop in the same cycle leave `level` unchanged.
  - Pointers wrap modulo DEPTH.
  - A pop while empty is ignored.
- Outputs are don't-care while `out_valid` is 0, but must be stable while `out_valid` is 1 and `out_ready` is 0.

## Timing
- Reset values:
  - state = A_HI.
  - `level` = 0 and pointers = 0.
  - `out_valid` = 0, `out_a` = 0, `out_b` = 0, `out_last` = 0.
  - `err_frame` = 0.
  - `in_ready` = 1.
- Latency: `out_valid` rises one cycle after the B_LO byte is accepted into an empty FIFO.
- Throughput: one pair per 4 accepted bytes. Pops can run every cycle.
- Full FIFO while the FSM is in B_LO and a pop occurs in the same cycle: `in_ready` is still 0 that cycle. The push happens on the next cycle.
- Reset mid-pair: the partial pair and all FIFO contents are lost. No output is produced from them.

## Configuration
Macro `DLF_LOADER_SANITIZE_EN`.
- Defined: the B_LO push applies a per-operand rewrite.
  - Exponent field [14:9] == 0 with a nonzero mantissa becomes 0x0000 (flush to zero). The sign bit is cleared.
  - Any operand equal to 0xFFFF (NaN) is kept.
  - Exponent 0x3F with a mantissa other than 0x1FF becomes 0xFFFF.
- Undefined: operands are pushed bit-exact.

## Structure
- Shared package `dlf_pkg` holds:
  - `DLF_W` = 16, `DLF_EXP_W` = 6, `DLF_MAN_W` = 9, `DLF_BIAS` = 31.
  - `DLF_NAN` = 16'hFFFF.
  - The `dlf_pair_t` struct {a, b, last}.
  - The loader FSM state enum.
- Sub-module `dlf_pair_fifo`: a parameterised synchronous FIFO of `dlf_pair_t` with push/pop, full/empty and level. The FSM and the optional sanitize logic stay in `dlfloat_operand_loader`.

## Test plan
1. Single pair: after reset, send bytes 3E,00,40,00 with `in_last` on the 4th and `out_ready`=1. Expect `out_valid` one cycle later with `out_a`=0x3E00, `out_b`=0x4000, `out_last`=1; then `level` returns to 0.
2. Backpressure: hold `out_ready`=0 and send 5 pairs with DEPTH=4. Expect `level`=4, and `in_ready`=0 only in B_LO of pair 5. Release `out_ready`: all 5 pairs arrive in order, pair 5 intact.
3. Simultaneous push/pop: with `level`=2, accept a B_LO byte and pop in the same cycle. Expect `level` to stay at 2.
4. Framing error: send 3E,00 with `in_last`=1 on the 2nd byte. Expect `err_frame`=1, no push, and the FSM at A_HI. The next 4 bytes 41,00,3E,00 yield A=0x4100, B=0x3E00.
5. Reset mid-pair: after 2 bytes, pulse `rst_n` low. Expect all outputs at reset values, with `err_frame` cleared. A following full pair is loaded correctly.
6. With `DLF_LOADER_SANITIZE_EN`: send A=0x0005, B=0xFFFF. Expect `out_a`=0x0000 and `out_b`=0xFFFF. Without the macro, expect `out_a`=0x0005.

Source files
------------

// File: rtl/dlf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dlf_pkg
//  Purpose  : Shared DLFloat16 constants, operand-pair type, loader FSM
//             state encoding and the operand sanitize helper.
//  Revision : 1.0  initial release
// ============================================================================
package dlf_pkg;

  localparam int DLF_W     = 16;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;
  localparam int DLF_BIAS  = 31;

  localparam logic [DLF_W-1:0] DLF_NAN = 16'hFFFF;

  typedef struct packed {
    logic [DLF_W-1:0] a;
    logic [DLF_W-1:0] b;
    logic             last;
  } dlf_pair_t;

  typedef enum logic [1:0] {
    ST_A_HI = 2'd0,
    ST_A_LO = 2'd1,
    ST_B_HI = 2'd2,
    ST_B_LO = 2'd3
  } dlf_ld_state_t;

  // Flush denormals to +0 and collapse every non-canonical all-ones-exponent
  // encoding onto the single NaN pattern the MAC understands.
  function automatic logic [DLF_W-1:0] dlf_sanitize(input logic [DLF_W-1:0] op);
    logic [DLF_EXP_W-1:0] w_exp;
    logic [DLF_MAN_W-1:0] w_man;
    logic [DLF_W-1:0]     w_res;
    w_exp = op[DLF_W-2 -: DLF_EXP_W];
    w_man = op[DLF_MAN_W-1:0];
    w_res = op;
    if (op == DLF_NAN) begin
      w_res = op;
    end else if ((w_exp == '0) && (w_man != '0)) begin
      w_res = '0;
    end else if ((w_exp == '1) && (w_man != '1)) begin
      w_res = DLF_NAN;
    end
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dlf_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dlf_pair_fifo
//  Purpose  : Synchronous FIFO of DLFloat16 operand pairs with occupancy
//             level; the head entry is presented combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module dlf_pair_fifo
  import dlf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  dlf_pair_t                push_data,
  input  logic                     pop,
  output dlf_pair_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int                 c_PTR_W      = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL_LEVEL = (c_PTR_W+1)'(DEPTH);

  dlf_pair_t            r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_level;
  logic                 w_push_en;
  logic                 w_pop_en;

  assign full      = (r_level == c_FULL_LEVEL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign head      = r_mem[r_rd_ptr];
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;

  // Storage and pointers; memory is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_en) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_en && !w_pop_en) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop_en && !w_push_en) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlfloat_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : dlfloat_operand_loader
//  Purpose  : Assembles byte-serial operands (A_HI, A_LO, B_HI, B_LO) into
//             DLFloat16 operand pairs and queues them for the MAC.
//  Options  : DLF_LOADER_SANITIZE_EN - rewrite denormal / non-canonical NaN
//             operands on push.
//  Revision : 1.0  initial release
// ============================================================================
module dlfloat_operand_loader
  import dlf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [DLF_W-1:0]         out_a,
  output logic [DLF_W-1:0]         out_b,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_frame
);

  dlf_ld_state_t    r_state;
  logic [DLF_W-1:0] r_a_q;
  logic [7:0]       r_b_hi;
  logic             r_err_frame;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_frame_err;
  logic             w_push;
  logic [DLF_W-1:0] w_b_full;
  dlf_pair_t        w_push_pair;
  dlf_pair_t        w_head;

  // Only the closing byte can stall: it is the one that needs a FIFO slot.
  assign in_ready    = (r_state != ST_B_LO) || !w_full;
  assign w_accept    = in_valid && in_ready;
  assign w_frame_err = w_accept && in_last && (r_state != ST_B_LO);
  assign w_push      = w_accept && (r_state == ST_B_LO);
  assign w_b_full    = {r_b_hi, in_data};

`ifdef DLF_LOADER_SANITIZE_EN
  assign w_push_pair.a    = dlf_sanitize(r_a_q);
  assign w_push_pair.b    = dlf_sanitize(w_b_full);
`else
  assign w_push_pair.a    = r_a_q;
  assign w_push_pair.b    = w_b_full;
`endif
  assign w_push_pair.last = in_last;

  // Assembly FSM: one state per accepted byte; a misplaced last tag aborts the pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_A_HI;
      r_a_q       <= '0;
      r_b_hi      <= '0;
      r_err_frame <= 1'b0;
    end else if (w_accept) begin
      if (w_frame_err) begin
        r_state     <= ST_A_HI;
        r_err_frame <= 1'b1;
      end else begin
        case (r_state)
          ST_A_HI: begin
            r_a_q[15:8] <= in_data;
            r_state     <= ST_A_LO;
          end
          ST_A_LO: begin
            r_a_q[7:0]  <= in_data;
            r_state     <= ST_B_HI;
          end
          ST_B_HI: begin
            r_b_hi      <= in_data;
            r_state     <= ST_B_LO;
          end
          default: begin
            r_state     <= ST_A_HI;
          end
        endcase
      end
    end
  end

  dlf_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_pair),
    .pop       (out_ready),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  assign out_valid = !w_empty;
  assign out_a     = w_head.a;
  assign out_b     = w_head.b;
  assign out_last  = w_head.last;
  assign err_frame = r_err_frame;

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dlfloat_operand_loader
//  Purpose  : Directed self-checking bench for dlfloat_operand_loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dlfloat_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic        err_frame;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dlfloat_operand_loader #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .err_frame (err_frame)
  );

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int waits;
    waits    = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int waits;
    waits     = 0;
    out_ready = 1'b1;
    while (level != 0 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    out_ready = 1'b0;
    n_vec++;
    if (level !== 3'd0) begin n_err++; $display("FAIL drain: level=%0d required 0", level); end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({out_valid, out_a, out_b, out_last, err_frame, in_ready, level} !== {1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL reset_values: valid=%0b a=%h b=%h last=%0b err=%0b rdy=%0b lvl=%0d required 0,0000,0000,0,0,1,0",
               out_valid, out_a, out_b, out_last, err_frame, in_ready, level);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_pair();
    out_ready = 1'b1;
    send_byte(8'h3E, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b1);
    n_vec++;
    if ({out_valid, out_a, out_b, out_last} !== {1'b1, 16'h3E00, 16'h4000, 1'b1}) begin
      n_err++;
      $display("FAIL single_pair: valid=%0b a=%h b=%h last=%0b required 1,3e00,4000,1", out_valid, out_a, out_b, out_last);
    end
    @(negedge clk);
    n_vec++;
    if (level !== 3'd0) begin n_err++; $display("FAIL single_pair_level: level=%0d required 0", level); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] ea [5];
    logic [15:0] eb [5];
    logic [4:0]  el;
    int          idx;
    logic        pending;
    logic        rdy_prev;
    for (int k = 0; k < 5; k++) begin
      ea[k] = {8'h3C + 8'(k), 8'h10 + 8'(k)};
      eb[k] = {8'h40 + 8'(k), 8'h20 + 8'(k)};
      el[k] = (k == 4);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_byte(ea[k][15:8], 1'b0);
      send_byte(ea[k][7:0], 1'b0);
      send_byte(eb[k][15:8], 1'b0);
      send_byte(eb[k][7:0], el[k]);
    end
    n_vec++;
    if (level !== 3'd4) begin n_err++; $display("FAIL bp_level_full: level=%0d required 4", level); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a_hi: in_ready=%0b required 1", in_ready); end
    send_byte(ea[4][15:8], 1'b0);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a_lo: in_ready=%0b required 1", in_ready); end
    send_byte(ea[4][7:0], 1'b0);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_b_hi: in_ready=%0b required 1", in_ready); end
    send_byte(eb[4][15:8], 1'b0);
    in_data  = eb[4][7:0];
    in_last  = 1'b1;
    in_valid = 1'b1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_b_lo: in_ready=%0b required 0", in_ready); end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || level !== 3'd4) begin
      n_err++;
      $display("FAIL bp_stall_hold: in_ready=%0b level=%0d required 0,4", in_ready, level);
    end
    out_ready = 1'b1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_on_pop: in_ready=%0b required 0", in_ready); end
    idx     = 0;
    pending = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        n_vec++;
        if (idx > 4) begin
          n_err++;
          $display("FAIL bp_extra_pair: a=%h b=%h required no pair", out_a, out_b);
        end else if ({out_a, out_b, out_last} !== {ea[idx], eb[idx], el[idx]}) begin
          n_err++;
          $display("FAIL bp_pair%0d: a=%h b=%h last=%0b required %h,%h,%0b",
                   idx, out_a, out_b, out_last, ea[idx], eb[idx], el[idx]);
        end
        idx++;
      end
      rdy_prev = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (pending && rdy_prev) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        pending  = 1'b0;
      end
    end
    n_vec++;
    if (idx !== 5 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL bp_pair_count: pairs=%0d pending=%0b required 5,0", idx, pending);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    send_byte(8'h31, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h32, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'h35, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h36, 1'b0);
    n_vec++;
    if (level !== 3'd2) begin n_err++; $display("FAIL pp_level_before: level=%0d required 2", level); end
    out_ready = 1'b1;
    send_byte(8'h06, 1'b1);
    out_ready = 1'b0;
    n_vec++;
    if (level !== 3'd2) begin n_err++; $display("FAIL pp_level_after: level=%0d required 2", level); end
    n_vec++;
    if ({out_a, out_b, out_last} !== {16'h3303, 16'h3404, 1'b0}) begin
      n_err++;
      $display("FAIL pp_head: a=%h b=%h last=%0b required 3303,3404,0", out_a, out_b, out_last);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if ({out_a, out_b, out_last} !== {16'h3505, 16'h3606, 1'b1}) begin
      n_err++;
      $display("FAIL pp_tail: a=%h b=%h last=%0b required 3505,3606,1", out_a, out_b, out_last);
    end
    drain();
  endtask

  task automatic test_frame_err();
    send_byte(8'h3E, 1'b0);
    send_byte(8'h00, 1'b1);
    n_vec++;
    if (err_frame !== 1'b1 || level !== 3'd0) begin
      n_err++;
      $display("FAIL frame_err_flag: err=%0b level=%0d required 1,0", err_frame, level);
    end
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h3E, 1'b0);
    send_byte(8'h00, 1'b0);
    n_vec++;
    if ({out_valid, out_a, out_b, out_last, err_frame} !== {1'b1, 16'h4100, 16'h3E00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL frame_err_recover: valid=%0b a=%h b=%h last=%0b err=%0b required 1,4100,3e00,0,1",
               out_valid, out_a, out_b, out_last, err_frame);
    end
    drain();
  endtask

  task automatic test_reset_mid_pair();
    out_ready = 1'b0;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h3A, 1'b0);
    send_byte(8'h5A, 1'b0);
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({out_valid, out_a, out_b, out_last, err_frame, in_ready, level} !== {1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL mid_reset_values: valid=%0b a=%h b=%h last=%0b err=%0b rdy=%0b lvl=%0d required 0,0000,0000,0,0,1,0",
               out_valid, out_a, out_b, out_last, err_frame, in_ready, level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
    n_vec++;
    if ({out_valid, out_a, out_b, out_last, level} !== {1'b1, 16'h1234, 16'h5678, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL mid_reset_pair: valid=%0b a=%h b=%h last=%0b lvl=%0d required 1,1234,5678,1,1",
               out_valid, out_a, out_b, out_last, level);
    end
    drain();
  endtask

  task automatic test_sanitize();
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    logic [15:0] exp_b1;
`ifdef DLF_LOADER_SANITIZE_EN
    exp_a0 = 16'h0000; exp_a1 = 16'h0000; exp_b1 = 16'hFFFF;
`else
    exp_a0 = 16'h0005; exp_a1 = 16'h8003; exp_b1 = 16'h7E01;
`endif
    send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
    n_vec++;
    if ({out_a, out_b} !== {exp_a0, 16'hFFFF}) begin
      n_err++;
      $display("FAIL sanitize_pair0: a=%h b=%h required %h,ffff", out_a, out_b, exp_a0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    send_byte(8'h80, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h01, 1'b1);
    n_vec++;
    if ({out_a, out_b, out_last} !== {exp_a1, exp_b1, 1'b1}) begin
      n_err++;
      $display("FAIL sanitize_pair1: a=%h b=%h last=%0b required %h,%h,1", out_a, out_b, out_last, exp_a1, exp_b1);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_backpressure();
    test_push_pop();
    test_frame_err();
    test_reset_mid_pair();
    test_sanitize();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
